// File: rtl/counter_nb.sv
// rtl/counter_nb.sv - WIDTH-generic up/down/step counter with load, terminal value, wrap/saturate and cascade carry
//
// Purpose: the counter counts over the range 0..bn_limit. It counts up by 1, down by 1
// or up by STEP, or it loads bn_D. At the boundary it either wraps or saturates.
// bn_cout is a combinational lookahead, so stages can be chained: the upper stage's
// bn_cin is driven by the lower stage's bn_cout.
//
// Ports:
//   bn_clk     in   rising-edge clock
//   bn_reset   in   asynchronous, active-high reset
//   bn_enable  in   operation enable (low = hold)
//   bn_cin     in   cascade count enable (gates counting modes, not load)
//   bn_mode    in   00 up-1, 01 down-1, 10 up-STEP, 11 load bn_D
//   bn_D       in   load value (not clamped to bn_limit)
//   bn_limit   in   terminal value
//   bn_wrap    in   1 = wrap at boundary, 0 = saturate
//   bn_Q       out  registered count
//   bn_rco     out  registered pulse: last edge wrapped
//   bn_sat     out  registered pulse: last edge was blocked by saturation
//   bn_load    out  registered pulse: last edge loaded bn_D
//   bn_cout    out  combinational: the next edge will wrap
module counter_nb #(
  parameter int WIDTH = 8,
  parameter int STEP  = 3
) (
  input  logic             bn_clk,
  input  logic             bn_reset,
  input  logic             bn_enable,
  input  logic             bn_cin,
  input  logic [1:0]       bn_mode,
  input  logic [WIDTH-1:0] bn_D,
  input  logic [WIDTH-1:0] bn_limit,
  input  logic             bn_wrap,
  output logic [WIDTH-1:0] bn_Q,
  output logic             bn_rco,
  output logic             bn_sat,
  output logic             bn_load,
  output logic             bn_cout
);

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] STEP_N = WIDTH'(STEP);

  logic [WIDTH-1:0] q_q, q_d;
  logic             rco_q, rco_d;
  logic             sat_q, sat_d;
  logic             load_q, load_d;

  logic [WIDTH:0]   step_sum;
  logic [WIDTH:0]   limit_x;
  logic [WIDTH:0]   limit_p1;
  logic [WIDTH-1:0] step_wrap_val;
  logic             count_en;
  logic             at_boundary;
  logic [WIDTH-1:0] wrap_val;
  logic [WIDTH-1:0] sat_val;

  // Boundary detection and the values used when a boundary is hit.
  always_comb begin
    limit_x  = {1'b0, bn_limit};
    limit_p1 = limit_x + (WIDTH+1)'(1);
    step_sum = {1'b0, q_q} + STEP_X;
    // When it is used, the true value s-(limit+1) is at most bn_limit, so
    // modulo-2^WIDTH arithmetic gives the exact value.
    step_wrap_val = q_q + STEP_N - (bn_limit + WIDTH'(1));

    at_boundary = 1'b0;
    wrap_val    = '0;
    sat_val     = '0;
    unique case (bn_mode)
      MODE_UP: begin
        at_boundary = (q_q >= bn_limit);
        wrap_val    = '0;
        sat_val     = bn_limit;
      end
      MODE_DOWN: begin
        at_boundary = (q_q == '0);
        wrap_val    = bn_limit;
        sat_val     = '0;
      end
      MODE_STEP: begin
        at_boundary = (step_sum > limit_x);
        // If the start point is already out of range, or one step spans more
        // than the whole range, the remainder is meaningless, so restart at 0.
        wrap_val    = ((q_q > bn_limit) || (STEP_X > limit_p1)) ? '0 : step_wrap_val;
        sat_val     = bn_limit;
      end
      default: begin
        at_boundary = 1'b0;
        wrap_val    = '0;
        sat_val     = '0;
      end
    endcase

    count_en = bn_enable & bn_cin & (bn_mode != MODE_LOAD);
    bn_cout  = count_en & bn_wrap & at_boundary;
  end

  // Next-state logic. The pulse outputs default to 0 on every edge.
  always_comb begin
    q_d    = q_q;
    rco_d  = 1'b0;
    sat_d  = 1'b0;
    load_d = 1'b0;
    if (bn_enable && (bn_mode == MODE_LOAD)) begin
      q_d    = bn_D;
      load_d = 1'b1;
    end else if (count_en) begin
      if (!at_boundary) begin
        unique case (bn_mode)
          MODE_UP:   q_d = q_q + WIDTH'(1);
          MODE_DOWN: q_d = q_q - WIDTH'(1);
          default:   q_d = step_sum[WIDTH-1:0];
        endcase
      end else if (bn_wrap) begin
        q_d   = wrap_val;
        rco_d = 1'b1;
      end else begin
        q_d   = sat_val;
        sat_d = 1'b1;
      end
    end
  end

  always_ff @(posedge bn_clk or posedge bn_reset) begin
    if (bn_reset) begin
      q_q    <= '0;
      rco_q  <= 1'b0;
      sat_q  <= 1'b0;
      load_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      rco_q  <= rco_d;
      sat_q  <= sat_d;
      load_q <= load_d;
    end
  end

  assign bn_Q    = q_q;
  assign bn_rco  = rco_q;
  assign bn_sat  = sat_q;
  assign bn_load = load_q;

endmodule

// File: tb/tb_counter_nb.sv
// tb/tb_counter_nb.sv - self-checking bench for counter_nb (WIDTH=4, STEP=3, plus a two-stage cascade)
module tb_counter_nb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       en, cin, wrap;
  logic [1:0] mode;
  logic [3:0] d, lim;
  logic [3:0] q;
  logic       rco, sat, ld, cout;

  counter_nb #(.WIDTH(4), .STEP(3)) dut (
    .bn_clk(clk), .bn_reset(rst), .bn_enable(en), .bn_cin(cin),
    .bn_mode(mode), .bn_D(d), .bn_limit(lim), .bn_wrap(wrap),
    .bn_Q(q), .bn_rco(rco), .bn_sat(sat), .bn_load(ld), .bn_cout(cout)
  );

  logic       c_en, c_cin, c_wrap;
  logic [1:0] c_mode;
  logic [3:0] c_d, c_lim;
  logic [3:0] lo_q, hi_q;
  logic       lo_rco, lo_sat, lo_ld, lo_cout;
  logic       hi_rco, hi_sat, hi_ld, hi_cout;

  counter_nb #(.WIDTH(4), .STEP(1)) u_lo (
    .bn_clk(clk), .bn_reset(rst), .bn_enable(c_en), .bn_cin(c_cin),
    .bn_mode(c_mode), .bn_D(c_d), .bn_limit(c_lim), .bn_wrap(c_wrap),
    .bn_Q(lo_q), .bn_rco(lo_rco), .bn_sat(lo_sat), .bn_load(lo_ld), .bn_cout(lo_cout)
  );

  counter_nb #(.WIDTH(4), .STEP(1)) u_hi (
    .bn_clk(clk), .bn_reset(rst), .bn_enable(c_en), .bn_cin(lo_cout),
    .bn_mode(c_mode), .bn_D(c_d), .bn_limit(c_lim), .bn_wrap(c_wrap),
    .bn_Q(hi_q), .bn_rco(hi_rco), .bn_sat(hi_sat), .bn_load(hi_ld), .bn_cout(hi_cout)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [3:0] q;
    logic       rco;
    logic       sat;
    logic       load;
  } obs_t;

  typedef struct packed {
    logic [1:0] m;
    logic [3:0] dv;
    logic       e;
    logic       c;
    logic       w;
    logic [3:0] l;
    logic       co;
    obs_t       x;
  } stim_t;

  obs_t       sb[$];
  logic [7:0] csb[$];

  function automatic stim_t mk(input logic [1:0] m, input logic [3:0] dv, input logic e, c, w,
                               input logic [3:0] l, input logic co,
                               input logic [3:0] xq, input logic xr, xs, xl);
    stim_t s;
    s.m = m; s.dv = dv; s.e = e; s.c = c; s.w = w; s.l = l; s.co = co;
    s.x = '{q: xq, rco: xr, sat: xs, load: xl};
    return s;
  endfunction

  // Drives one stimulus row on the falling edge, samples the lookahead before the
  // rising edge, queues the expected registered result, and steps one edge.
  task automatic apply(input stim_t s, output logic co_obs);
    @(negedge clk);
    mode = s.m; d = s.dv; en = s.e; cin = s.c; wrap = s.w; lim = s.l;
    #1;
    co_obs = cout;
    sb.push_back(s.x);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t  exp;
    stim_t s;
    logic  co;
    rst = 1'b1; en = 1'b0; cin = 1'b1; wrap = 1'b1; mode = 2'b00; d = 4'd0; lim = 4'd9;
    #2;
    n_tests++;
    if ({q, rco, sat, ld} !== 7'b0) begin
      n_fail++; $display("FAIL reset_initial: got %b want %b", {q, rco, sat, ld}, 7'b0);
    end
    @(negedge clk); rst = 1'b0;
    s = mk(2'b11, 4'd5, 1, 1, 1, 4'd9, 1'b0, 4'd5, 0, 0, 1);
    apply(s, co);
    exp = sb.pop_front();
    n_tests++;
    if ({q, rco, sat, ld} !== exp) begin
      n_fail++; $display("FAIL reset_load5: got %b want %b", {q, rco, sat, ld}, exp);
    end
    // Reset between edges, with counting set up for the next edge.
    @(negedge clk);
    mode = 2'b00; en = 1'b1; cin = 1'b1; rst = 1'b1;
    #1;
    n_tests++;
    if ({q, rco, sat, ld} !== 7'b0) begin
      n_fail++; $display("FAIL reset_async: got %b want %b", {q, rco, sat, ld}, 7'b0);
    end
    #1 rst = 1'b0;
    sb.push_back('{q: 4'd1, rco: 1'b0, sat: 1'b0, load: 1'b0});
    @(posedge clk); #1;
    exp = sb.pop_front();
    n_tests++;
    if ({q, rco, sat, ld} !== exp) begin
      n_fail++; $display("FAIL reset_resume: got %b want %b", {q, rco, sat, ld}, exp);
    end
  endtask

  task automatic test_load();
    stim_t t[$];
    obs_t  exp;
    logic  co;
    t.push_back(mk(2'b11, 4'd7, 1, 0, 1, 4'd9, 1'b0, 4'd7, 0, 0, 1));
    t.push_back(mk(2'b00, 4'd0, 1, 1, 1, 4'd9, 1'b0, 4'd8, 0, 0, 0));
    t.push_back(mk(2'b00, 4'd0, 0, 1, 1, 4'd9, 1'b0, 4'd8, 0, 0, 0));
    t.push_back(mk(2'b00, 4'd0, 1, 0, 1, 4'd9, 1'b0, 4'd8, 0, 0, 0));
    t.push_back(mk(2'b11, 4'd3, 0, 1, 1, 4'd9, 1'b0, 4'd8, 0, 0, 0));
    foreach (t[i]) begin
      apply(t[i], co);
      n_tests++;
      if (co !== t[i].co) begin
        n_fail++; $display("FAIL load_cout[%0d]: got %b want %b", i, co, t[i].co);
      end
      exp = sb.pop_front();
      n_tests++;
      if ({q, rco, sat, ld} !== exp) begin
        n_fail++; $display("FAIL load[%0d]: got %b want %b", i, {q, rco, sat, ld}, exp);
      end
    end
  endtask

  task automatic test_up_wrap();
    stim_t t[$];
    obs_t  exp;
    logic  co;
    t.push_back(mk(2'b00, 4'd0, 1, 1, 1, 4'd9, 1'b0, 4'd9, 0, 0, 0));
    t.push_back(mk(2'b00, 4'd0, 1, 1, 1, 4'd9, 1'b1, 4'd0, 1, 0, 0));
    t.push_back(mk(2'b00, 4'd0, 1, 1, 1, 4'd9, 1'b0, 4'd1, 0, 0, 0));
    t.push_back(mk(2'b11, 4'd9, 1, 1, 1, 4'd9, 1'b0, 4'd9, 0, 0, 1));
    t.push_back(mk(2'b00, 4'd0, 1, 1, 0, 4'd9, 1'b0, 4'd9, 0, 1, 0));
    t.push_back(mk(2'b00, 4'd0, 1, 1, 0, 4'd9, 1'b0, 4'd9, 0, 1, 0));
    t.push_back(mk(2'b00, 4'd0, 1, 1, 1, 4'd0, 1'b1, 4'd0, 1, 0, 0));
    t.push_back(mk(2'b00, 4'd0, 1, 1, 1, 4'd0, 1'b1, 4'd0, 1, 0, 0));
    foreach (t[i]) begin
      apply(t[i], co);
      n_tests++;
      if (co !== t[i].co) begin
        n_fail++; $display("FAIL up_cout[%0d]: got %b want %b", i, co, t[i].co);
      end
      exp = sb.pop_front();
      n_tests++;
      if ({q, rco, sat, ld} !== exp) begin
        n_fail++; $display("FAIL up[%0d]: got %b want %b", i, {q, rco, sat, ld}, exp);
      end
    end
  endtask

  task automatic test_step();
    stim_t t[$];
    obs_t  exp;
    logic  co;
    t.push_back(mk(2'b11, 4'd8,  1, 1, 1, 4'd9, 1'b0, 4'd8,  0, 0, 1));
    t.push_back(mk(2'b10, 4'd0,  1, 1, 1, 4'd9, 1'b1, 4'd1,  1, 0, 0));
    t.push_back(mk(2'b10, 4'd0,  1, 1, 1, 4'd9, 1'b0, 4'd4,  0, 0, 0));
    t.push_back(mk(2'b11, 4'd8,  1, 1, 0, 4'd9, 1'b0, 4'd8,  0, 0, 1));
    t.push_back(mk(2'b10, 4'd0,  1, 1, 0, 4'd9, 1'b0, 4'd9,  0, 1, 0));
    t.push_back(mk(2'b10, 4'd0,  1, 1, 0, 4'd9, 1'b0, 4'd9,  0, 1, 0));
    t.push_back(mk(2'b10, 4'd0,  1, 1, 0, 4'd9, 1'b0, 4'd9,  0, 1, 0));
    t.push_back(mk(2'b11, 4'd12, 1, 1, 1, 4'd9, 1'b0, 4'd12, 0, 0, 1));
    t.push_back(mk(2'b10, 4'd0,  1, 1, 1, 4'd9, 1'b1, 4'd0,  1, 0, 0));
    t.push_back(mk(2'b10, 4'd0,  1, 1, 1, 4'd1, 1'b1, 4'd0,  1, 0, 0));
    t.push_back(mk(2'b11, 4'd4,  1, 1, 1, 4'd5, 1'b0, 4'd4,  0, 0, 1));
    t.push_back(mk(2'b10, 4'd0,  1, 1, 1, 4'd5, 1'b1, 4'd1,  1, 0, 0));
    foreach (t[i]) begin
      apply(t[i], co);
      n_tests++;
      if (co !== t[i].co) begin
        n_fail++; $display("FAIL step_cout[%0d]: got %b want %b", i, co, t[i].co);
      end
      exp = sb.pop_front();
      n_tests++;
      if ({q, rco, sat, ld} !== exp) begin
        n_fail++; $display("FAIL step[%0d]: got %b want %b", i, {q, rco, sat, ld}, exp);
      end
    end
  endtask

  task automatic test_down();
    stim_t t[$];
    obs_t  exp;
    logic  co;
    t.push_back(mk(2'b11, 4'd0,  1, 1, 1, 4'd9, 1'b0, 4'd0,  0, 0, 1));
    t.push_back(mk(2'b01, 4'd0,  1, 1, 1, 4'd9, 1'b1, 4'd9,  1, 0, 0));
    t.push_back(mk(2'b01, 4'd0,  1, 1, 1, 4'd9, 1'b0, 4'd8,  0, 0, 0));
    t.push_back(mk(2'b11, 4'd0,  1, 1, 0, 4'd9, 1'b0, 4'd0,  0, 0, 1));
    t.push_back(mk(2'b01, 4'd0,  1, 1, 0, 4'd9, 1'b0, 4'd0,  0, 1, 0));
    t.push_back(mk(2'b01, 4'd0,  1, 1, 0, 4'd9, 1'b0, 4'd0,  0, 1, 0));
    t.push_back(mk(2'b11, 4'd15, 1, 1, 1, 4'd9, 1'b0, 4'd15, 0, 0, 1));
    t.push_back(mk(2'b01, 4'd0,  1, 1, 1, 4'd9, 1'b0, 4'd14, 0, 0, 0));
    t.push_back(mk(2'b11, 4'd0,  1, 1, 1, 4'd0, 1'b0, 4'd0,  0, 0, 1));
    t.push_back(mk(2'b01, 4'd0,  1, 1, 1, 4'd0, 1'b1, 4'd0,  1, 0, 0));
    foreach (t[i]) begin
      apply(t[i], co);
      n_tests++;
      if (co !== t[i].co) begin
        n_fail++; $display("FAIL down_cout[%0d]: got %b want %b", i, co, t[i].co);
      end
      exp = sb.pop_front();
      n_tests++;
      if ({q, rco, sat, ld} !== exp) begin
        n_fail++; $display("FAIL down[%0d]: got %b want %b", i, {q, rco, sat, ld}, exp);
      end
    end
  endtask

  task automatic test_cascade();
    logic [7:0] cnt;
    logic [7:0] exp;
    c_en = 1'b0; c_cin = 1'b1; c_wrap = 1'b1; c_mode = 2'b00; c_d = 4'd0; c_lim = 4'd15;
    @(negedge clk); rst = 1'b1;
    #1;
    n_tests++;
    if ({hi_q, lo_q} !== 8'd0) begin
      n_fail++; $display("FAIL cascade_reset: got %0d want 0", {hi_q, lo_q});
    end
    #1 rst = 1'b0;
    cnt = 8'd0;
    for (int i = 1; i <= 305; i++) begin
      @(negedge clk);
      c_en = (i <= 300);
      if (i <= 300) cnt = cnt + 8'd1;
      csb.push_back(cnt);
      @(posedge clk); #1;
      exp = csb.pop_front();
      n_tests++;
      if ({hi_q, lo_q} !== exp) begin
        n_fail++; $display("FAIL cascade[%0d]: got %0d want %0d", i, {hi_q, lo_q}, exp);
      end
    end
    n_tests++;
    if ({hi_q, lo_q} !== 8'd44) begin
      n_fail++; $display("FAIL cascade_final: got %0d want 44", {hi_q, lo_q});
    end
  endtask

  initial begin
    c_en = 1'b0; c_cin = 1'b1; c_wrap = 1'b1; c_mode = 2'b00; c_d = 4'd0; c_lim = 4'd15;
    test_reset();
    test_load();
    test_up_wrap();
    test_step();
    test_down();
    test_cascade();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
